// File: rtl/vc_ctrl.sv
// Victim-cache controller: fully associative tag/valid store steering a line-wide data RAM.
// Evicts write the RAM in their acceptance cycle; lookups respond one cycle later, one outstanding.
module vc_ctrl #(
    parameter int VC_WAYS_EXP = 2,
    parameter int WORD_SEL    = 4,
    parameter int TAG_WT      = 26,
    parameter int LINE_DWT    = 512,
    parameter int LSU_DC_DWT  = 32,
    parameter int LSU_DC_SWT  = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   flush_i,
    input  logic                   evict_vld_i,
    output logic                   evict_rdy_o,
    input  logic [TAG_WT-1:0]      evict_tag_i,
    input  logic [LINE_DWT-1:0]    evict_line_i,
    input  logic                   req_vld_i,
    output logic                   req_rdy_o,
    input  logic                   req_wr_i,
    input  logic [TAG_WT-1:0]      req_tag_i,
    input  logic [WORD_SEL-1:0]    req_word_i,
    input  logic [LSU_DC_SWT-1:0]  req_strobe_i,
    input  logic [LSU_DC_DWT-1:0]  req_wdata_i,
    output logic                   rsp_vld_o,
    output logic                   rsp_hit_o,
    output logic [LSU_DC_DWT-1:0]  rsp_rdata_o,
    output logic                   ram_wr_en_o,
    output logic                   ram_wr_line_en_o,
    output logic [VC_WAYS_EXP-1:0] ram_wr_way_o,
    output logic [WORD_SEL-1:0]    ram_wr_word_en_o,
    output logic [LSU_DC_SWT-1:0]  ram_wr_data_strobe_o,
    output logic [LINE_DWT-1:0]    ram_wr_data_o,
    output logic                   ram_rd_en_o,
    output logic [VC_WAYS_EXP-1:0] ram_rd_way_o,
    output logic [WORD_SEL-1:0]    ram_rd_word_en_o,
    input  logic [LSU_DC_DWT-1:0]  ram_rd_word_i
);

    localparam int VC_WAYS = 2**VC_WAYS_EXP;

    typedef enum logic [0:0] {ST_IDLE, ST_RESP} state_t;

    state_t                   r_state;
    logic [VC_WAYS-1:0]       r_valid;
    logic [TAG_WT-1:0]        r_tag [VC_WAYS];
    logic [VC_WAYS_EXP-1:0]   r_rr_ptr;
    logic                     r_hit;
    logic                     r_load;

    logic                     w_ev_match;
    logic [VC_WAYS_EXP-1:0]   w_ev_match_way;
    logic                     w_inv_any;
    logic [VC_WAYS_EXP-1:0]   w_inv_way;
    logic                     w_hit;
    logic [VC_WAYS_EXP-1:0]   w_hit_way;
    logic [VC_WAYS_EXP-1:0]   w_victim;
    logic                     w_evict_acc;
    logic                     w_req_acc;

    // Descending scan so the lowest-index way wins every priority search.
    always_comb begin
        w_ev_match     = 1'b0;
        w_ev_match_way = '0;
        w_inv_any      = 1'b0;
        w_inv_way      = '0;
        w_hit          = 1'b0;
        w_hit_way      = '0;
        for (int i = VC_WAYS-1; i >= 0; i--) begin
            if (r_valid[i] && (r_tag[i] == evict_tag_i)) begin
                w_ev_match     = 1'b1;
                w_ev_match_way = VC_WAYS_EXP'(i);
            end
            if (!r_valid[i]) begin
                w_inv_any = 1'b1;
                w_inv_way = VC_WAYS_EXP'(i);
            end
            if (r_valid[i] && (r_tag[i] == req_tag_i)) begin
                w_hit     = 1'b1;
                w_hit_way = VC_WAYS_EXP'(i);
            end
        end
    end

    assign w_victim    = w_ev_match ? w_ev_match_way : (w_inv_any ? w_inv_way : r_rr_ptr);
    assign evict_rdy_o = !rst_i && (r_state == ST_IDLE) && !flush_i;
    assign req_rdy_o   = evict_rdy_o && !evict_vld_i;
    assign w_evict_acc = evict_vld_i && evict_rdy_o;
    assign w_req_acc   = req_vld_i && req_rdy_o;

    always_comb begin
        ram_wr_en_o          = 1'b0;
        ram_wr_line_en_o     = 1'b0;
        ram_wr_way_o         = '0;
        ram_wr_word_en_o     = '0;
        ram_wr_data_strobe_o = '0;
        ram_wr_data_o        = '0;
        ram_rd_en_o          = 1'b0;
        ram_rd_way_o         = '0;
        ram_rd_word_en_o     = '0;
        if (w_evict_acc) begin
            ram_wr_en_o      = 1'b1;
            ram_wr_line_en_o = 1'b1;
            ram_wr_way_o     = w_victim;
            ram_wr_data_o    = evict_line_i;
        end else if (w_req_acc && w_hit && req_wr_i) begin
            ram_wr_en_o          = 1'b1;
            ram_wr_way_o         = w_hit_way;
            ram_wr_word_en_o     = req_word_i;
            ram_wr_data_strobe_o = req_strobe_i;
            ram_wr_data_o        = LINE_DWT'(req_wdata_i);
        end else if (w_req_acc && w_hit) begin
            ram_rd_en_o      = 1'b1;
            ram_rd_way_o     = w_hit_way;
            ram_rd_word_en_o = req_word_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state  <= ST_IDLE;
            r_valid  <= '0;
            r_rr_ptr <= '0;
            r_hit    <= 1'b0;
            r_load   <= 1'b0;
            for (int i = 0; i < VC_WAYS; i++) begin
                r_tag[i] <= '0;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_evict_acc) begin
                        r_valid[w_victim] <= 1'b1;
                        r_tag[w_victim]   <= evict_tag_i;
                        if (!w_ev_match && !w_inv_any) begin
                            r_rr_ptr <= r_rr_ptr + 1'b1;
                        end
                    end else if (w_req_acc) begin
                        r_state <= ST_RESP;
                        r_hit   <= w_hit;
                        r_load  <= !req_wr_i;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
            // Flush never touches the captured response flags.
            if (flush_i) begin
                r_valid  <= '0;
                r_rr_ptr <= '0;
            end
        end
    end

    assign rsp_vld_o   = (r_state == ST_RESP);
    assign rsp_hit_o   = rsp_vld_o && r_hit;
    assign rsp_rdata_o = (rsp_vld_o && r_hit && r_load) ? ram_rd_word_i : '0;

endmodule
